// File: rtl/wb_cas_mem_responder.sv
// Wishbone slave: single-port word memory plus a compare-and-swap engine that
// performs the read-compare-write sequence at the memory so no master can interleave.
module wb_cas_mem_responder #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] CAS_BASE  = 32'h7fff_fff0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [2:0]  wb_cti_i,
    input  logic [1:0]  wb_bte_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o
);

    localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    localparam logic [1:0] OFS_ADDR = 2'd0;
    localparam logic [1:0] OFS_CMP  = 2'd1;
    localparam logic [1:0] OFS_EXEC = 2'd2;
    localparam logic [1:0] OFS_STAT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESP,
        S_ERR,
        S_CAS_RD,
        S_CAS_CMP
    } state_e;

    state_e      state_q;
    logic [31:0] mem_q [MEM_WORDS];
    logic [31:0] ram_rdata_q;
    logic [31:0] reg_rdata_q;
    logic        dat_from_ram_q;
    logic [31:0] cas_addr_q;
    logic [31:0] cas_cmp_q;
    logic [31:0] cas_res_q;
    logic [31:0] cas_swap_q;
    logic        cas_stat_q;
    logic        ack_q;
    logic        err_q;

    logic          req_c;
    logic          mem_hit_c;
    logic          cas_hit_c;
    logic [1:0]    cas_ofs_c;
    logic          cas_tgt_ok_c;
    logic          cas_match_c;
    logic          ram_we_c;
    logic [3:0]    ram_be_c;
    logic [AW-1:0] ram_widx_c;
    logic [AW-1:0] ram_ridx_c;
    logic [31:0]   ram_wdata_c;
    logic          unused_c;

    assign req_c        = wb_cyc_i & wb_stb_i;
    assign mem_hit_c    = (wb_adr_i[31:AW+2] == '0);
    assign cas_hit_c    = (wb_adr_i[31:4] == CAS_BASE[31:4]);
    assign cas_ofs_c    = wb_adr_i[3:2];
    assign cas_tgt_ok_c = (cas_addr_q[31:AW+2] == '0);
    assign cas_match_c  = (ram_rdata_q == cas_cmp_q);
    assign unused_c     = ^{wb_adr_i[1:0], wb_cti_i, wb_bte_i, cas_addr_q[1:0]};

    // Single RAM port: bus access in IDLE, CAS target read/write in the CAS states
    always_comb begin
        ram_we_c    = 1'b0;
        ram_be_c    = 4'h0;
        ram_widx_c  = wb_adr_i[AW+1:2];
        ram_ridx_c  = wb_adr_i[AW+1:2];
        ram_wdata_c = wb_dat_i;
        if (state_q == S_CAS_RD) begin
            ram_ridx_c = cas_addr_q[AW+1:2];
        end
        if (state_q == S_IDLE && req_c && mem_hit_c && wb_we_i) begin
            ram_we_c = 1'b1;
            ram_be_c = wb_sel_i;
        end
        if (state_q == S_CAS_CMP && cas_match_c) begin
            ram_we_c    = 1'b1;
            ram_be_c    = 4'hF;
            ram_widx_c  = cas_addr_q[AW+1:2];
            ram_wdata_c = cas_swap_q;
        end
    end

    // Memory array is not reset; a reset edge suppresses any pending write
    always_ff @(posedge clk_i) begin
        ram_rdata_q <= mem_q[ram_ridx_c];
        if (ram_we_c && !rst_i) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_be_c[b]) begin
                    mem_q[ram_widx_c][8*b +: 8] <= ram_wdata_c[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= S_IDLE;
            ack_q          <= 1'b0;
            err_q          <= 1'b0;
            reg_rdata_q    <= '0;
            dat_from_ram_q <= 1'b0;
            cas_addr_q     <= '0;
            cas_cmp_q      <= '0;
            cas_res_q      <= '0;
            cas_swap_q     <= '0;
            cas_stat_q     <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (req_c) begin
                        reg_rdata_q    <= '0;
                        dat_from_ram_q <= 1'b0;
                        if (mem_hit_c) begin
                            dat_from_ram_q <= !wb_we_i;
                            ack_q          <= 1'b1;
                            state_q        <= S_RESP;
                        end else if (cas_hit_c && !wb_we_i) begin
                            unique case (cas_ofs_c)
                                OFS_ADDR: reg_rdata_q <= cas_addr_q;
                                OFS_CMP:  reg_rdata_q <= cas_cmp_q;
                                OFS_EXEC: reg_rdata_q <= cas_res_q;
                                default:  reg_rdata_q <= {31'b0, cas_stat_q};
                            endcase
                            ack_q   <= 1'b1;
                            state_q <= S_RESP;
                        end else if (cas_hit_c && wb_sel_i == 4'hF && cas_ofs_c != OFS_STAT) begin
                            unique case (cas_ofs_c)
                                OFS_ADDR: begin
                                    cas_addr_q <= wb_dat_i;
                                    ack_q      <= 1'b1;
                                    state_q    <= S_RESP;
                                end
                                OFS_CMP: begin
                                    cas_cmp_q <= wb_dat_i;
                                    ack_q     <= 1'b1;
                                    state_q   <= S_RESP;
                                end
                                default: begin
                                    cas_swap_q <= wb_dat_i;
                                    state_q    <= S_CAS_RD;
                                end
                            endcase
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= S_ERR;
                        end
                    end
                end
                S_CAS_RD: begin
                    if (!cas_tgt_ok_c) begin
                        cas_stat_q <= 1'b0;
                        err_q      <= 1'b1;
                        state_q    <= S_ERR;
                    end else begin
                        state_q <= S_CAS_CMP;
                    end
                end
                S_CAS_CMP: begin
                    cas_res_q  <= ram_rdata_q;
                    cas_stat_q <= cas_match_c;
                    ack_q      <= 1'b1;
                    state_q    <= S_RESP;
                end
                default: begin
                    reg_rdata_q    <= '0;
                    dat_from_ram_q <= 1'b0;
                    state_q        <= S_IDLE;
                end
            endcase
        end
    end

    assign wb_dat_o = dat_from_ram_q ? ram_rdata_q : reg_rdata_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_cas_mem_responder.sv
// Bench for wb_cas_mem_responder: directed scenarios plus random traffic checked
// against a word-array model of the memory and CAS registers.
module tb_wb_cas_mem_responder;

    localparam int unsigned MEM_WORDS = 1024;
    localparam logic [31:0] CAS_BASE  = 32'h7fff_fff0;
    localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic        wb_we_i  = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic [2:0]  wb_cti_i = '0;
    logic [1:0]  wb_bte_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;

    wb_cas_mem_responder #(.MEM_WORDS(MEM_WORDS), .CAS_BASE(CAS_BASE)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem_m [MEM_WORDS];
    logic [31:0] cas_addr_m = '0;
    logic [31:0] cas_cmp_m  = '0;
    logic [31:0] cas_res_m  = '0;
    logic        cas_stat_m = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: what a single bus access should do, straight from the register map
    task automatic model(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                         input logic we, output logic [31:0] exp_rd, output logic exp_err,
                         output int exp_lat);
        int idx;
        logic [31:0] old;
        exp_rd  = '0;
        exp_err = 1'b0;
        exp_lat = 1;
        if (adr < MEM_BYTES) begin
            idx = int'(adr >> 2);
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (sel[b]) mem_m[idx][8*b +: 8] = dat[8*b +: 8];
            end else begin
                exp_rd = mem_m[idx];
            end
        end else if (adr[31:4] == CAS_BASE[31:4]) begin
            if (!we) begin
                case (adr[3:2])
                    2'd0:    exp_rd = cas_addr_m;
                    2'd1:    exp_rd = cas_cmp_m;
                    2'd2:    exp_rd = cas_res_m;
                    default: exp_rd = {31'b0, cas_stat_m};
                endcase
            end else if (sel != 4'hF || adr[3:2] == 2'd3) begin
                exp_err = 1'b1;
            end else if (adr[3:2] == 2'd0) begin
                cas_addr_m = dat;
            end else if (adr[3:2] == 2'd1) begin
                cas_cmp_m = dat;
            end else if (cas_addr_m >= MEM_BYTES) begin
                cas_stat_m = 1'b0;
                exp_err    = 1'b1;
                exp_lat    = 2;
            end else begin
                idx       = int'(cas_addr_m >> 2);
                old       = mem_m[idx];
                cas_res_m = old;
                if (old == cas_cmp_m) begin
                    mem_m[idx] = dat;
                    cas_stat_m = 1'b1;
                end else begin
                    cas_stat_m = 1'b0;
                end
                exp_lat = 3;
            end
        end else begin
            exp_err = 1'b1;
        end
    endtask

    task automatic bus(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                       input logic we, output logic [31:0] rd, output logic ack,
                       output logic err, output int lat);
        @(posedge clk_i); #1;
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
        wb_cti_i = 3'($urandom); wb_bte_i = 2'($urandom);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        rd = '0; ack = 1'b0; err = 1'b0; lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk_i); #1;
            if (wb_ack_o || wb_err_o) begin
                rd = wb_dat_o; ack = wb_ack_o; err = wb_err_o; lat = i;
                break;
            end
        end
        check_eq("rty", 32'(wb_rty_o), 32'd0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic we, output logic [31:0] rd);
        logic [31:0] exp_rd;
        logic        exp_err, ack, err;
        int          exp_lat, lat;
        model(adr, dat, sel, we, exp_rd, exp_err, exp_lat);
        bus(adr, dat, sel, we, rd, ack, err, lat);
        check_eq({tag, "_ack"}, 32'(ack), 32'(!exp_err));
        check_eq({tag, "_err"}, 32'(err), 32'(exp_err));
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        if (!we && !exp_err) check_eq({tag, "_rdata"}, rd, exp_rd);
    endtask

    function automatic logic [31:0] pick_addr();
        int idx;
        idx = $urandom_range(0, 64);
        if (idx == 64) idx = MEM_WORDS - 1;
        return 32'(idx * 4 + $urandom_range(0, 3));
    endfunction

    initial begin
        logic [31:0] rd, a;
        int r, idx;

        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_ack", 32'(wb_ack_o), 32'd0);
        check_eq("rst_err", 32'(wb_err_o), 32'd0);
        check_eq("rst_rty", 32'(wb_rty_o), 32'd0);
        check_eq("rst_dat", wb_dat_o, 32'd0);
        rst_i = 1'b0;

        do_op("rst_addr", CAS_BASE + 0, 0, 4'hF, 1'b0, rd);
        do_op("rst_stat", CAS_BASE + 12, 0, 4'hF, 1'b0, rd);

        for (int i = 0; i < 64; i++) do_op("init", 32'(i * 4), $urandom, 4'hF, 1'b1, rd);
        do_op("init_top", MEM_BYTES - 4, $urandom, 4'hF, 1'b1, rd);

        do_op("wr10", 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, rd);
        do_op("rd10", 32'h10, 0, 4'h0, 1'b0, rd);
        check_eq("rd10_lit", rd, 32'hDEADBEEF);
        do_op("wr20", 32'h20, 32'h11223344, 4'hF, 1'b1, rd);
        do_op("wr20_sel", 32'h20, 32'hAABBCCDD, 4'b0101, 1'b1, rd);
        do_op("rd20", 32'h22, 0, 4'h1, 1'b0, rd);
        check_eq("rd20_lit", rd, 32'h11BB33DD);

        do_op("wr40", 32'h40, 32'd5, 4'hF, 1'b1, rd);
        do_op("cas_addr", CAS_BASE + 0, 32'h40, 4'hF, 1'b1, rd);
        do_op("cas_cmp", CAS_BASE + 4, 32'd5, 4'hF, 1'b1, rd);
        do_op("cas_exec", CAS_BASE + 8, 32'd9, 4'hF, 1'b1, rd);
        do_op("cas_mem", 32'h40, 0, 4'hF, 1'b0, rd);
        check_eq("cas_mem_lit", rd, 32'd9);
        do_op("cas_res", CAS_BASE + 8, 0, 4'hF, 1'b0, rd);
        check_eq("cas_res_lit", rd, 32'd5);
        do_op("cas_stat", CAS_BASE + 12, 0, 4'hF, 1'b0, rd);
        check_eq("cas_stat_lit", rd, 32'd1);
        do_op("cas2_exec", CAS_BASE + 8, 32'd7, 4'hF, 1'b1, rd);
        do_op("cas2_mem", 32'h40, 0, 4'hF, 1'b0, rd);
        check_eq("cas2_mem_lit", rd, 32'd9);
        do_op("cas2_res", CAS_BASE + 8, 0, 4'hF, 1'b0, rd);
        check_eq("cas2_res_lit", rd, 32'd9);
        do_op("cas2_stat", CAS_BASE + 12, 0, 4'hF, 1'b0, rd);
        check_eq("cas2_stat_lit", rd, 32'd0);

        do_op("err_top", MEM_BYTES, 32'h1234, 4'hF, 1'b1, rd);
        do_op("err_top_rd", MEM_BYTES, 0, 4'hF, 1'b0, rd);
        do_op("last_word", MEM_BYTES - 1, 0, 4'hF, 1'b0, rd);
        do_op("err_set_addr", CAS_BASE + 0, 32'h0FFF_FFF0, 4'hF, 1'b1, rd);
        do_op("err_exec", CAS_BASE + 8, 32'h55, 4'hF, 1'b1, rd);
        do_op("err_exec_stat", CAS_BASE + 12, 0, 4'hF, 1'b0, rd);
        check_eq("err_exec_stat_lit", rd, 32'd0);
        do_op("err_cmp_sel", CAS_BASE + 4, 32'hFFFF_FFFF, 4'h3, 1'b1, rd);
        do_op("err_cmp_keep", CAS_BASE + 4, 0, 4'hF, 1'b0, rd);
        check_eq("err_cmp_keep_lit", rd, 32'd5);
        do_op("err_stat_wr", CAS_BASE + 12, 32'd1, 4'hF, 1'b1, rd);

        // Abandon a swapping CAS by resetting during its compare cycle
        do_op("mid_addr", CAS_BASE + 0, 32'h40, 4'hF, 1'b1, rd);
        do_op("mid_cmp", CAS_BASE + 4, mem_m[16], 4'hF, 1'b1, rd);
        @(posedge clk_i); #1;
        wb_adr_i = CAS_BASE + 8; wb_dat_i = 32'hCAFE_F00D; wb_sel_i = 4'hF; wb_we_i = 1'b1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        @(posedge clk_i); #1;
        check_eq("mid_ack1", 32'({wb_ack_o, wb_err_o}), 32'd0);
        @(posedge clk_i); #1;
        check_eq("mid_ack2", 32'({wb_ack_o, wb_err_o}), 32'd0);
        rst_i = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(posedge clk_i); #1;
        check_eq("mid_ack3", 32'({wb_ack_o, wb_err_o}), 32'd0);
        rst_i = 1'b0;
        cas_addr_m = '0; cas_cmp_m = '0; cas_res_m = '0; cas_stat_m = 1'b0;
        do_op("mid_rd_addr", CAS_BASE + 0, 0, 4'hF, 1'b0, rd);
        do_op("mid_rd_cmp", CAS_BASE + 4, 0, 4'hF, 1'b0, rd);
        do_op("mid_rd_res", CAS_BASE + 8, 0, 4'hF, 1'b0, rd);
        do_op("mid_rd_mem", 32'h40, 0, 4'hF, 1'b0, rd);

        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: do_op("rnd_mwr", pick_addr(), $urandom, 4'($urandom), 1'b1, rd);
                3, 4:    do_op("rnd_mrd", pick_addr(), 0, 4'($urandom), 1'b0, rd);
                5: begin
                    a = ($urandom_range(0, 7) == 0) ? ($urandom | MEM_BYTES) : pick_addr();
                    do_op("rnd_addr", CAS_BASE + 0, a, 4'hF, 1'b1, rd);
                end
                6: begin
                    if (cas_addr_m < MEM_BYTES && $urandom_range(0, 2) != 0) begin
                        idx = int'(cas_addr_m >> 2);
                        a = mem_m[idx];
                    end else begin
                        a = $urandom;
                    end
                    do_op("rnd_cmp", CAS_BASE + 4, a, 4'hF, 1'b1, rd);
                end
                7: do_op("rnd_exec", CAS_BASE + 8, $urandom, 4'hF, 1'b1, rd);
                8: do_op("rnd_rreg", CAS_BASE + 32'($urandom_range(0, 15)), 0, 4'($urandom), 1'b0, rd);
                default: begin
                    case ($urandom_range(0, 2))
                        0: do_op("rnd_unmap", MEM_BYTES + 32'($urandom_range(0, 4095)), $urandom,
                                 4'hF, 1'($urandom), rd);
                        1: do_op("rnd_statwr", CAS_BASE + 12, $urandom, 4'hF, 1'b1, rd);
                        default: do_op("rnd_badsel", CAS_BASE + 32'($urandom_range(0, 2) * 4),
                                       $urandom, 4'($urandom_range(0, 14)), 1'b1, rd);
                    endcase
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/wb_cas_mem_responder.md
Name: wb_cas_mem_responder

Overview:
Target-side Wishbone slave: single-port word memory plus a memory-mapped compare-and-swap engine. It serves ordinary reads/writes and executes CAS atomically at the memory end, so no other master can interleave between the compare and the swap. It sits behind the bus interconnect, opposite the core-side CAS initiators.

Parameters:
MEM_WORDS, 1024, memory depth in 32-bit words; power of two, at least 2.
CAS_BASE, 32'h7ffffff0, byte address of the 16-byte CAS register window; 16-byte aligned.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
wb_adr_i  in  32  byte address
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte selects
wb_we_i  in  1  write enable
wb_cyc_i  in  1  cycle valid
wb_stb_i  in  1  strobe
wb_cti_i  in  3  cycle type; ignored, every beat is treated as classic
wb_bte_i  in  2  burst type; ignored
wb_dat_o  out  32  read data
wb_ack_o  out  1  normal termination
wb_err_o  out  1  error termination
wb_rty_o  out  1  retry; tied 0

Behaviour:
- Reset (synchronous, rst_i high at clock edge):
  - FSM goes to IDLE; wb_ack_o, wb_err_o, wb_rty_o = 0; wb_dat_o = 0.
  - CAS_ADDR, CAS_CMP, CAS_RES, CAS_STAT = 0.
  - Memory contents are not cleared.
  - Reset mid-operation abandons the operation; no ack or err is issued.
  - A CAS memory write is either fully done or not done, because it happens on a single edge.
- Address decode, on word address (wb_adr_i[1:0] ignored):
  - MEM: wb_adr_i < MEM_WORDS*4.
  - CAS window: CAS_BASE+0 ADDR, +4 CMP, +8 EXEC, +C STAT.
  - Anything else: err.
- CAS registers:
  - ADDR (RW): byte address of the target word.
  - CMP (RW): expected value.
  - EXEC, write: data is the swap value and triggers the CAS.
  - EXEC, read: returns CAS_RES, the old memory value of the last CAS.
  - STAT (RO): bit0 = 1 if the last CAS swapped; other bits 0. A write to STAT gives err.
  - Writes to the CAS window require wb_sel_i == 4'hF, else err and no state change.
- A request is cyc_i & stb_i while in IDLE. Every termination (ack or err) is a single-cycle pulse, then IDLE. A request held high after its termination is treated as a new request on the following IDLE cycle.
- States:
  - IDLE:
    - MEM read: issue RAM read, go to RESP.
    - MEM write: write RAM bytes per sel on this edge, go to RESP.
    - CAS register read/write (not EXEC write): access register, go to RESP.
    - EXEC write: latch swap value, go to CAS_RD.
    - Decode error: go to ERR.
  - CAS_RD: if ADDR is outside MEM: CAS_STAT=0, memory untouched, go to ERR. Else issue RAM read of ADDR[..:2], go to CAS_CMP.
  - CAS_CMP: CAS_RES = RAM data. If it equals CMP (all 32 bits): write swap value to RAM, CAS_STAT=1. Else CAS_STAT=0, no write. Go to RESP.
  - RESP: wb_ack_o=1 for one cycle; wb_dat_o valid for reads; go to IDLE.
  - ERR: wb_err_o=1 for one cycle; go to IDLE.
- Latency, counted as cycles from the request edge to the ack cycle:
  - MEM read/write and register access: 1 (ack on the cycle after the request).
  - EXEC write: 3.
  - Errors: 1.
  - EXEC write with ADDR out of range: 2.
- Reads of MEM return the full word regardless of sel.
- If cyc_i drops mid-CAS, the CAS still completes and the termination is still pulsed. The master must ignore it.
- Back-to-back: maximum throughput is one access per 2 cycles.
- ADDR[1:0] is ignored for the CAS target word.

Test Plan:
- Reset, then write 0xDEADBEEF to MEM 0x10, then read 0x10 -> ack 1 cycle after each request; read returns 0xDEADBEEF; err/rty stay 0.
- Write 0x11223344 to 0x20, then write 0xAABBCCDD to 0x20 with sel=4'b0101 -> read returns 0x11BB33DD.
- MEM[0x40]=5. ADDR=0x40, CMP=5, write 9 to EXEC -> ack 3 cycles after the request. MEM[0x40]=9, EXEC read=5, STAT read=1.
- Repeat the previous CAS with CMP=5 while MEM=9, swap=7 -> MEM stays 9, EXEC read=9, STAT=0.
- Error cases, each giving one err pulse and no state change:
  - access to MEM_WORDS*4;
  - ADDR=0x0FFFFFF0 then EXEC write (STAT=0 after);
  - write to CMP with sel=4'h3.
- Assert rst_i in the CAS_CMP cycle -> no ack, registers read 0, MEM[target] unchanged.
